// File: rtl/mmio_intc.sv
// mmio_intc: IF/IE interrupt controller with priority arbiter and req/ack CPU dispatch.
// Define INTC_EDGE_DETECT_EN to capture sources on rising edges instead of as pulses.
module mmio_intc #(
  parameter int NUM_SRC = 5,
  parameter logic [15:0] VEC_BASE = 16'h0040,
  parameter int VEC_STRIDE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [15:0] addr_select,
  input  logic write_enable,
  input  logic [7:0] write_value,
  output logic [7:0] read_out,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic ime,
  input  logic int_ack,
  output logic int_req,
  output logic [15:0] int_vector,
  output logic halt_wake
);
  localparam int IW = $clog2(NUM_SRC);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_n;
  logic [NUM_SRC-1:0] if_r, if_n, pend, set, clr;
  logic [7:0] ie;
  logic [1:0] cnt_if, cnt_ie;
  logic [IW-1:0] sel_idx, winner;
  logic hit_if, hit_ie, commit_if, commit_ie, ack;
`ifdef INTC_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] src_q;
  always_ff @(posedge clk) src_q <= rst ? '0 : irq_src;
  assign set = irq_src & ~src_q;
`else
  assign set = irq_src;
`endif
  assign hit_if = write_enable && addr_select == 16'hff0f;
  assign hit_ie = write_enable && addr_select == 16'hffff;
  assign commit_if = hit_if && cnt_if == 2'd1;
  assign commit_ie = hit_ie && cnt_ie == 2'd1;
  assign pend = if_r & ie[NUM_SRC-1:0];
  assign ack = state == REQ && int_ack;
  assign clr = ack ? NUM_SRC'(1) << sel_idx : '0;
  // write replaces, ack clears, source sets win last
  assign if_n = ((commit_if ? write_value[NUM_SRC-1:0] : if_r) & ~clr) | set;
  assign read_out = addr_select == 16'hff0f ? {{(8-NUM_SRC){1'b1}}, if_r} :
                    addr_select == 16'hffff ? ie : 8'haa;
  assign int_req = state == REQ;
  assign int_vector = VEC_BASE + 16'(VEC_STRIDE * int'(sel_idx));
  assign halt_wake = |pend;
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pend[i]) winner = IW'(i);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = ime && |pend ? REQ : IDLE;
      REQ: state_n = int_ack ? DONE : (!ime || !pend[sel_idx]) ? IDLE : REQ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      if_r <= '0;
      ie <= '0;
      cnt_if <= '0;
      cnt_ie <= '0;
      sel_idx <= '0;
    end else begin
      state <= state_n;
      if_r <= if_n;
      if (commit_ie) ie <= write_value;
      cnt_if <= hit_if ? cnt_if + 2'(cnt_if != 2'd2) : 2'd0;
      cnt_ie <= hit_ie ? cnt_ie + 2'(cnt_ie != 2'd2) : 2'd0;
      if (state == IDLE && state_n == REQ) sel_idx <= winner;
    end
  end
endmodule

// File: tb/tb_mmio_intc.sv
// tb_mmio_intc: directed bench for mmio_intc with a cycle-level reference model and literal spot checks.
module tb_mmio_intc;
  logic clk = 0, rst = 1;
  logic [15:0] addr_select = '0;
  logic write_enable = 0;
  logic [7:0] write_value = '0;
  logic [7:0] read_out;
  logic [4:0] irq_src = '0;
  logic ime = 0, int_ack = 0;
  logic int_req, halt_wake;
  logic [15:0] int_vector;
  int n_cmp = 0, n_bad = 0;
  bit started = 0;
  bit [4:0] m_if, m_srcq;
  bit [7:0] m_ie;
  int m_ph, m_sel, run_if, run_ie;
  mmio_intc dut (
    .clk(clk), .rst(rst), .addr_select(addr_select), .write_enable(write_enable),
    .write_value(write_value), .read_out(read_out), .irq_src(irq_src), .ime(ime),
    .int_ack(int_ack), .int_req(int_req), .int_vector(int_vector), .halt_wake(halt_wake)
  );
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [15:0] a, logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction
  // model: phase 0 waiting, 1 requesting, 2 cooldown
  always @(posedge clk) begin
    bit [4:0] nif, pnd, st;
    bit c_if, c_ie, ak;
    started = 1;
    if (rst) begin
      m_if = 0; m_ie = 0; m_ph = 0; m_sel = 0; run_if = 0; run_ie = 0; m_srcq = 0;
    end else begin
      c_if = write_enable && addr_select == 16'hff0f && run_if == 1;
      c_ie = write_enable && addr_select == 16'hffff && run_ie == 1;
      run_if = (write_enable && addr_select == 16'hff0f) ? run_if + 1 : 0;
      run_ie = (write_enable && addr_select == 16'hffff) ? run_ie + 1 : 0;
`ifdef INTC_EDGE_DETECT_EN
      st = irq_src & ~m_srcq;
`else
      st = irq_src;
`endif
      m_srcq = irq_src;
      pnd = m_if & m_ie[4:0];
      ak = m_ph == 1 && int_ack;
      nif = c_if ? write_value[4:0] : m_if;
      if (ak) nif[m_sel] = 0;
      m_if = nif | st;
      if (c_ie) m_ie = write_value;
      if (m_ph == 0) begin
        if (ime && pnd != 0) begin
          for (int i = 0; i < 5; i++) if (pnd[i]) begin m_sel = i; break; end
          m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (ak) m_ph = 2;
        else if (!ime || !pnd[m_sel]) m_ph = 0;
      end else m_ph = 0;
    end
  end
  always @(negedge clk) if (started) begin
    chk("int_req", int_req, 16'(m_ph == 1));
    if (m_ph == 1) chk("int_vector", int_vector, 16'(64 + 8 * m_sel));
    chk("halt_wake", halt_wake, 16'(|(m_if & m_ie[4:0])));
    chk("read_out", read_out, addr_select == 16'hff0f ? {8'h0, 3'b111, m_if} :
        addr_select == 16'hffff ? {8'h0, m_ie} : 16'h00aa);
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] v);
    addr_select = a; write_enable = 1; write_value = v;
    tick(); tick();
    write_enable = 0; addr_select = '0;
  endtask
  task automatic rd(input string n, input logic [15:0] a, input logic [7:0] e);
    addr_select = a;
    #1;
    chk(n, {8'h0, read_out}, {8'h0, e});
  endtask
  task automatic pulse(input logic [4:0] m);
    irq_src = m; tick(); irq_src = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(); tick();
    rst = 0;
    // T1 reset
    wr(16'hff0f, 8'h1f);
    wr(16'hffff, 8'hff);
    rd("t1_if_pre", 16'hff0f, 8'hff);
    chk("t1_wake_pre", 16'(halt_wake), 16'h1);
    rst = 1; tick(); rst = 0;
    rd("t1_if", 16'hff0f, 8'he0);
    rd("t1_ie", 16'hffff, 8'h00);
    chk("t1_req", 16'(int_req), 16'h0);
    tick();
    rd("t1_other", 16'h1234, 8'haa);
    // T2 timer dispatch
    wr(16'hffff, 8'h04);
    ime = 1;
    pulse(5'h04);
    chk("t2_lat", 16'(int_req), 16'h0);
    tick();
    chk("t2_req", 16'(int_req), 16'h1);
    chk("t2_vec", int_vector, 16'h0050);
    int_ack = 1; tick(); int_ack = 0;
    chk("t2_done", 16'(int_req), 16'h0);
    rd("t2_if", 16'hff0f, 8'he0);
    tick();
    chk("t2_idle", 16'(int_req), 16'h0);
    // T3 priority
    wr(16'hffff, 8'h1f);
    pulse(5'h12);
    tick();
    chk("t3_vec1", int_vector, 16'h0048);
    int_ack = 1; tick(); int_ack = 0;
    chk("t3_done", 16'(int_req), 16'h0);
    tick();
    chk("t3_gap", 16'(int_req), 16'h0);
    tick();
    chk("t3_req2", 16'(int_req), 16'h1);
    chk("t3_vec2", int_vector, 16'h0060);
    int_ack = 1; tick(); int_ack = 0;
    tick(); tick();
    // T4 withdrawal
    pulse(5'h01);
    tick();
    chk("t4_vec", int_vector, 16'h0040);
    wr(16'hff0f, 8'h00);
    chk("t4_still", 16'(int_req), 16'h1);
    tick();
    chk("t4_drop", 16'(int_req), 16'h0);
    tick();
    chk("t4_idle", 16'(int_req), 16'h0);
    // T5 set/clear collision
    pulse(5'h04);
    tick();
    chk("t5_vec", int_vector, 16'h0050);
    int_ack = 1; irq_src = 5'h04; tick(); int_ack = 0; irq_src = '0;
    rd("t5_if", 16'hff0f, 8'he4);
    chk("t5_done", 16'(int_req), 16'h0);
    tick();
    tick();
    chk("t5_req2", 16'(int_req), 16'h1);
    chk("t5_vec2", int_vector, 16'h0050);
    int_ack = 1; tick(); int_ack = 0;
    tick(); tick();
    // T6 halt wake
    ime = 0;
    wr(16'hffff, 8'h01);
    pulse(5'h01);
    chk("t6_wake", 16'(halt_wake), 16'h1);
    int_ack = 1; tick(); int_ack = 0;
    rd("t6_if", 16'hff0f, 8'he1);
    chk("t6_noreq", 16'(int_req), 16'h0);
    wr(16'hff0f, 8'h00);
    chk("t6_sleep", 16'(halt_wake), 16'h0);
    wr(16'hffff, 8'ha5);
    rd("t6_ie8", 16'hffff, 8'ha5);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
